// File: rtl/mdu_pkg.sv
// Shared MDU constants: op encodings, default latencies, FSM states, payload types
// and the combinational multiply/divide datapath used at completion.
package mdu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int unsigned MDU_MULT_CYCLES = 5;
   localparam int unsigned MDU_DIV_CYCLES  = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } hilo_t;

   typedef struct packed {
      logic            sgn;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } operands_t;

   // Low 64 bits of the extended-operand product are correct for both signednesses.
   function automatic hilo_t mdu_mul(input operands_t o);
      logic [2*XLEN-1:0] ea;
      logic [2*XLEN-1:0] eb;
      logic [2*XLEN-1:0] p;
      hilo_t             r;
      ea   = {{XLEN{o.sgn & o.a[XLEN-1]}}, o.a};
      eb   = {{XLEN{o.sgn & o.b[XLEN-1]}}, o.b};
      p    = ea * eb;
      r.hi = p[2*XLEN-1:XLEN];
      r.lo = p[XLEN-1:0];
      return r;
   endfunction

   // Magnitude divide keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
   function automatic hilo_t mdu_div(input operands_t o);
      logic            a_neg;
      logic            b_neg;
      logic [XLEN-1:0] ma;
      logic [XLEN-1:0] mb;
      logic [XLEN-1:0] qm;
      logic [XLEN-1:0] rm;
      hilo_t           r;
      a_neg = o.sgn & o.a[XLEN-1];
      b_neg = o.sgn & o.b[XLEN-1];
      ma    = a_neg ? (~o.a + XLEN'(1)) : o.a;
      mb    = b_neg ? (~o.b + XLEN'(1)) : o.b;
      if (mb == '0) begin
         mb = XLEN'(1);
      end
      qm    = ma / mb;
      rm    = ma % mb;
      r.lo  = (a_neg ^ b_neg) ? (~qm + XLEN'(1)) : qm;
      r.hi  = a_neg ? (~rm + XLEN'(1)) : rm;
      return r;
   endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: fixed-latency MULT/DIV, immediate MTHI/MTLO,
// and a combinational RD read port for mfhi/mflo.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            hilo_sel,
   output logic            busy,
   output logic [XLEN-1:0] RD,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   operands_t        opnd_q;
   operands_t        opnd_d;
   logic [XLEN-1:0]  hi_d;
   logic [XLEN-1:0]  lo_d;
   logic             busy_d;
   hilo_t            mul_res;
   hilo_t            div_res;
   logic             done;
   logic             accept;

   assign mul_res = mdu_mul(opnd_q);
   assign div_res = mdu_div(opnd_q);

   // The completion edge doubles as an accepting edge so a new op can chain with no gap.
   assign done   = (state_q != ST_IDLE) && (cnt_q == '0);
   assign accept = (state_q == ST_IDLE) || done;

   assign RD = hilo_sel ? HI : LO;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opnd_d  = opnd_q;
      hi_d    = HI;
      lo_d    = LO;
      busy_d  = busy;

      case (state_q)
         ST_IDLE: begin
         end
         ST_MUL: begin
            if (done) begin
               hi_d    = mul_res.hi;
               lo_d    = mul_res.lo;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DIV: begin
            if (done) begin
               // Divide by zero burns the full latency but leaves HI/LO alone.
               if (opnd_q.b != '0) begin
                  hi_d = div_res.hi;
                  lo_d = div_res.lo;
               end
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase

      if (start && accept) begin
         case (op)
            OP_MULT, OP_MULTU: begin
               state_d    = ST_MUL;
               busy_d     = 1'b1;
               cnt_d      = MUL_LOAD;
               opnd_d.sgn = (op == OP_MULT);
               opnd_d.a   = A;
               opnd_d.b   = B;
            end
            OP_DIV, OP_DIVU: begin
               state_d    = ST_DIV;
               busy_d     = 1'b1;
               cnt_d      = DIV_LOAD;
               opnd_d.sgn = (op == OP_DIV);
               opnd_d.a   = A;
               opnd_d.b   = B;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opnd_q  <= '0;
         HI      <= '0;
         LO      <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         HI      <= hi_d;
         LO      <= lo_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed and random MULT/DIV/MT traffic against an
// integer-arithmetic reference model.
module tb_mdu;

   localparam int unsigned NMUL = 5;
   localparam int unsigned NDIV = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        hilo_sel;
   logic        busy;
   logic [31:0] RD;
   logic [31:0] HI;
   logic [31:0] LO;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mdu #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .hilo_sel(hilo_sel), .busy(busy), .RD(RD), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint p;
      if (sgn) p = longint'($signed(a)) * longint'($signed(b));
      else     p = longint'({32'd0, a}) * longint'({32'd0, b});
      return 64'(p);
   endfunction

   // Returns {remainder, quotient}; integer division truncates toward zero.
   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint la;
      longint lb;
      longint q;
      longint r;
      la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      q  = la / lb;
      r  = la % lb;
      return {32'(r), 32'(q)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      cyc();
      start = 1'b0;
      op    = 3'd0;
      A     = $urandom;
      B     = $urandom;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         n++;
         cyc();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cyc();
      start = 1'b1; op = 3'd6; A = 32'hDEAD_BEEF;
      cyc();
      start = 1'b0; op = 3'd0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0 (start under reset)", LO); end
      checks++; if (RD !== 32'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", RD); end
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_mult();
      logic [31:0] a;
      logic [31:0] b;
      bit          sgn;
      logic [63:0] p;
      int          n;
      for (int i = 0; i < 10; i++) begin
         if (i < 2) begin a = 32'hFFFF_FFFE; b = 32'd3; sgn = (i == 0); end
         else begin a = $urandom; b = $urandom; sgn = bit'($urandom_range(0, 1)); end
         p = ref_mul(sgn, a, b);
         issue(sgn ? 3'd1 : 3'd2, a, b);
         checks++; if (HI !== exp_hi || LO !== exp_lo) begin
            errors++; $display("FAIL mult_early_write i=%0d got=%h_%h exp=%h_%h", i, HI, LO, exp_hi, exp_lo);
         end
         wait_idle(n);
         exp_hi = p[63:32];
         exp_lo = p[31:0];
         checks++; if (n != NMUL) begin errors++; $display("FAIL mult_busy_len i=%0d got=%0d exp=%0d", i, n, NMUL); end
         checks++; if (HI !== exp_hi) begin errors++; $display("FAIL mult_hi i=%0d a=%h b=%h s=%0d got=%h exp=%h", i, a, b, sgn, HI, exp_hi); end
         checks++; if (LO !== exp_lo) begin errors++; $display("FAIL mult_lo i=%0d a=%h b=%h s=%0d got=%h exp=%h", i, a, b, sgn, LO, exp_lo); end
      end
   endtask

   task automatic test_div();
      logic [31:0] a;
      logic [31:0] b;
      bit          sgn;
      logic [63:0] r;
      int          n;
      for (int i = 0; i < 12; i++) begin
         case (i)
            0: begin a = 32'hFFFF_FFF9; b = 32'd2;         sgn = 1'b1; end
            1: begin a = 32'd7;         b = 32'd0;         sgn = 1'b0; end
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sgn = 1'b1; end
            3: begin a = 32'd100;       b = 32'hFFFF_FFF9; sgn = 1'b1; end
            4: begin a = $urandom;      b = 32'd0;         sgn = 1'b1; end
            default: begin
               a = $urandom;
               b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
               if ($urandom_range(0, 1) == 0) b = -b;
               sgn = bit'($urandom_range(0, 1));
            end
         endcase
         issue(sgn ? 3'd3 : 3'd4, a, b);
         wait_idle(n);
         if (b != 32'd0) begin
            r = ref_div(sgn, a, b);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
         end
         checks++; if (n != NDIV) begin errors++; $display("FAIL div_busy_len i=%0d got=%0d exp=%0d", i, n, NDIV); end
         checks++; if (HI !== exp_hi) begin errors++; $display("FAIL div_hi i=%0d a=%h b=%h s=%0d got=%h exp=%h", i, a, b, sgn, HI, exp_hi); end
         checks++; if (LO !== exp_lo) begin errors++; $display("FAIL div_lo i=%0d a=%h b=%h s=%0d got=%h exp=%h", i, a, b, sgn, LO, exp_lo); end
      end
   endtask

   task automatic test_mt_rd();
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom;
      y = $urandom;
      issue(3'd5, x, 32'd0);
      exp_hi = x;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
      checks++; if (HI !== exp_hi) begin errors++; $display("FAIL mthi_hi got=%h exp=%h", HI, exp_hi); end
      issue(3'd6, y, 32'd0);
      exp_lo = y;
      checks++; if (LO !== exp_lo) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", LO, exp_lo); end
      issue(3'd0, 32'h1111_1111, 32'd2);
      issue(3'd7, 32'h2222_2222, 32'd3);
      cyc();
      checks++; if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         errors++; $display("FAIL noop_ops got busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", busy, HI, LO, exp_hi, exp_lo);
      end
      hilo_sel = 1'b1; #1;
      checks++; if (RD !== exp_hi) begin errors++; $display("FAIL rd_hi got=%h exp=%h", RD, exp_hi); end
      hilo_sel = 1'b0; #1;
      checks++; if (RD !== exp_lo) begin errors++; $display("FAIL rd_lo got=%h exp=%h", RD, exp_lo); end
   endtask

   task automatic test_ignore_busy();
      int n;
      issue(3'd3, 32'd100, 32'd7);
      cyc();
      cyc();
      issue(3'd5, 32'h1234_5678, 32'd0);
      issue(3'd1, 32'd9, 32'd9);
      wait_idle(n);
      exp_hi = 32'd2;
      exp_lo = 32'd14;
      checks++; if (n + 4 != NDIV) begin errors++; $display("FAIL ignore_busy_len got=%0d exp=%0d", n + 4, NDIV); end
      checks++; if (HI !== exp_hi) begin errors++; $display("FAIL ignore_hi got=%h exp=%h", HI, exp_hi); end
      checks++; if (LO !== exp_lo) begin errors++; $display("FAIL ignore_lo got=%h exp=%h", LO, exp_lo); end
      issue(3'd5, 32'h1234_5678, 32'd0);
      exp_hi = 32'h1234_5678;
      checks++; if (HI !== exp_hi) begin errors++; $display("FAIL mthi_after got=%h exp=%h", HI, exp_hi); end
   endtask

   task automatic test_reset_mid();
      issue(3'd1, 32'd5, 32'd6);
      cyc();
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", HI, LO); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      cyc();
      reset = 1'b1;
      for (int k = 0; k < 8; k++) cyc();
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      checks++; if (LO !== exp_lo || HI !== exp_hi || busy !== 1'b0) begin
         errors++; $display("FAIL rst_mid_after got hi=%h lo=%h busy=%b exp 0/0/0", HI, LO, busy);
      end
   endtask

   task automatic test_back_to_back();
      hilo_sel = 1'b0;
      issue(3'd1, 32'd5, 32'd6);
      for (int k = 0; k < 4; k++) cyc();
      issue(3'd1, 32'd2, 32'd2);
      checks++; if (LO !== 32'd30 || RD !== 32'd30) begin errors++; $display("FAIL b2b_first got lo=%0d rd=%0d exp=30", LO, RD); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy=%b exp=1", busy); end
      cyc();
      cyc();
      checks++; if (RD !== 32'd30) begin errors++; $display("FAIL b2b_rd_mid got=%0d exp=30", RD); end
      cyc();
      cyc();
      cyc();
      checks++; if (LO !== 32'd4 || RD !== 32'd4 || HI !== 32'd0) begin
         errors++; $display("FAIL b2b_second got hi=%0d lo=%0d rd=%0d exp 0/4/4", HI, LO, RD);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0; hilo_sel = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_mt_rd();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
